// File: rtl/count_yi_pkg.sv
// Shared definitions for the descending index generators: FSM encoding and default index width.
package count_yi_pkg;

    localparam int DEFAULT_BITS_OF_END_NUMBER = 10;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_e;

endpackage

// File: rtl/count_down_yi.sv
// Single-level down counter: captures its bounds on load, steps down on enable,
// and reloads the high bound once it has reached (or started at/below) the low bound.
module count_down_yi
    import count_yi_pkg::*;
#(
    parameter int BITS_OF_END_NUMBER = DEFAULT_BITS_OF_END_NUMBER
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic                          enable,
    input  logic [BITS_OF_END_NUMBER-1:0] high_number,
    input  logic [BITS_OF_END_NUMBER-1:0] low_number,
    output logic [BITS_OF_END_NUMBER-1:0] q,
    output logic                          last
);

    localparam logic [BITS_OF_END_NUMBER-1:0] ONE = 1;

    logic [BITS_OF_END_NUMBER-1:0] high_q;
    logic [BITS_OF_END_NUMBER-1:0] low_q;

    // Unsigned <= so a high bound below the low bound yields one value and q never underflows.
    assign last = (q <= low_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q      <= '0;
            high_q <= '0;
            low_q  <= '0;
        end else if (load) begin
            q      <= high_number;
            high_q <= high_number;
            low_q  <= low_number;
        end else if (enable) begin
            if (last) begin
                q <= high_q;
            end else begin
                q <= q - ONE;
            end
        end
    end

endmodule

// File: rtl/count_down_nest_yi.sv
// Two-level descending (outer, inner) index generator presented on a valid/ready stream,
// used for reverse-order read-back of buffers written in ascending order.
module count_down_nest_yi
    import count_yi_pkg::*;
#(
    parameter int BITS_OF_END_NUMBER = DEFAULT_BITS_OF_END_NUMBER
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [BITS_OF_END_NUMBER-1:0] in_high_number,
    input  logic [BITS_OF_END_NUMBER-1:0] in_low_number,
    input  logic [BITS_OF_END_NUMBER-1:0] out_high_number,
    input  logic [BITS_OF_END_NUMBER-1:0] out_low_number,
    input  logic                          addr_ready,
    output logic                          addr_valid,
    output logic [BITS_OF_END_NUMBER-1:0] inner_q,
    output logic [BITS_OF_END_NUMBER-1:0] outer_q,
    output logic                          inner_last,
    output logic                          seq_last,
    output logic                          busy,
    output logic                          done
);

    state_e state_q;
    logic   addr_valid_q;
    logic   busy_q;
    logic   done_q;

    logic   load;
    logic   beat;
    logic   innerAtLow;
    logic   outerAtLow;
    logic   innerEnable;
    logic   outerEnable;

    assign load       = (state_q == ST_IDLE) && start;
    assign beat       = addr_valid_q && addr_ready;
    assign inner_last = addr_valid_q && innerAtLow;
    assign seq_last   = inner_last && outerAtLow;

    // Counters freeze on the final beat so the last pair stays visible after the run.
    assign innerEnable = beat && !seq_last;
    assign outerEnable = beat && inner_last && !seq_last;

    count_down_yi #(.BITS_OF_END_NUMBER(BITS_OF_END_NUMBER)) u_inner (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .enable     (innerEnable),
        .high_number(in_high_number),
        .low_number (in_low_number),
        .q          (inner_q),
        .last       (innerAtLow)
    );

    count_down_yi #(.BITS_OF_END_NUMBER(BITS_OF_END_NUMBER)) u_outer (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .enable     (outerEnable),
        .high_number(out_high_number),
        .low_number (out_low_number),
        .q          (outer_q),
        .last       (outerAtLow)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            addr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q      <= ST_RUN;
                        addr_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (beat && seq_last) begin
                        state_q      <= ST_DONE;
                        addr_valid_q <= 1'b0;
                        done_q       <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    addr_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                end
            endcase
        end
    end

    assign addr_valid = addr_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_count_down_nest_yi.sv
// Directed bench for count_down_nest_yi: hand-written expected pair lists checked cycle by cycle.
module tb_count_down_nest_yi;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] in_high_number;
    logic [W-1:0] in_low_number;
    logic [W-1:0] out_high_number;
    logic [W-1:0] out_low_number;
    logic         addr_ready;
    logic         addr_valid;
    logic [W-1:0] inner_q;
    logic [W-1:0] outer_q;
    logic         inner_last;
    logic         seq_last;
    logic         busy;
    logic         done;

    int assertCount = 0;
    int failCount   = 0;

    int expOuter[$];
    int expInner[$];
    bit expIl[$];
    bit expSl[$];

    always #5 clk = ~clk;

    count_down_nest_yi #(.BITS_OF_END_NUMBER(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .in_high_number (in_high_number),
        .in_low_number  (in_low_number),
        .out_high_number(out_high_number),
        .out_low_number (out_low_number),
        .addr_ready     (addr_ready),
        .addr_valid     (addr_valid),
        .inner_q        (inner_q),
        .outer_q        (outer_q),
        .inner_last     (inner_last),
        .seq_last       (seq_last),
        .busy           (busy),
        .done           (done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input logic v, input int inner, input int outer,
                              input logic il, input logic sl, input logic b, input logic d);
        checkOutput({tag, ".valid"}, 32'(addr_valid), 32'(v));
        checkOutput({tag, ".inner"}, 32'(inner_q), inner);
        checkOutput({tag, ".outer"}, 32'(outer_q), outer);
        checkOutput({tag, ".inner_last"}, 32'(inner_last), 32'(il));
        checkOutput({tag, ".seq_last"}, 32'(seq_last), 32'(sl));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(b));
        checkOutput({tag, ".done"}, 32'(done), 32'(d));
    endtask

    task automatic addExp(input int o, input int i, input bit il, input bit sl);
        expOuter.push_back(o);
        expInner.push_back(i);
        expIl.push_back(il);
        expSl.push_back(sl);
    endtask

    // Pulse start with the given bounds, then scramble the bound inputs to show they are not re-read.
    task automatic applyStimulus(input int ih, input int il, input int oh, input int ol);
        in_high_number  = W'(ih);
        in_low_number   = W'(il);
        out_high_number = W'(oh);
        out_low_number  = W'(ol);
        start           = 1'b1;
        tick();
        start           = 1'b0;
        in_high_number  = 10'h2AA;
        in_low_number   = 10'h000;
        out_high_number = 10'h155;
        out_low_number  = 10'h3FF;
    endtask

    task automatic runSequence(input string tag, input int ih, input int il, input int oh, input int ol,
                               input bit backpressure, input bit pokeStart);
        int idx = 0;
        int cyc = 0;
        int n   = expOuter.size();
        applyStimulus(ih, il, oh, ol);
        while (idx < n && cyc < 40) begin
            addr_ready = backpressure ? (cyc % 2 == 0) : 1'b1;
            start      = pokeStart && (cyc == 1 || cyc == 3);
            checkState($sformatf("%s.cyc%0d", tag, cyc), 1'b1, expInner[idx], expOuter[idx],
                       expIl[idx], expSl[idx], 1'b1, 1'b0);
            if (addr_ready) idx++;
            tick();
            cyc++;
        end
        start      = 1'b0;
        addr_ready = 1'b1;
        checkOutput({tag, ".beats"}, idx, n);
        checkOutput({tag, ".cycles"}, cyc, backpressure ? (2 * n - 1) : n);
        checkState({tag, ".donecyc"}, 1'b0, expInner[n-1], expOuter[n-1], 1'b0, 1'b0, 1'b1, 1'b1);
        start = pokeStart;
        tick();
        start = 1'b0;
        checkState({tag, ".idle"}, 1'b0, expInner[n-1], expOuter[n-1], 1'b0, 1'b0, 1'b0, 1'b0);
        expOuter.delete();
        expInner.delete();
        expIl.delete();
        expSl.delete();
    endtask

    task automatic addBasic();
        addExp(1, 3, 0, 0);
        addExp(1, 2, 0, 0);
        addExp(1, 1, 1, 0);
        addExp(0, 3, 0, 0);
        addExp(0, 2, 0, 0);
        addExp(0, 1, 1, 1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset           = 1'b0;
        start           = 1'b0;
        addr_ready      = 1'b0;
        in_high_number  = '0;
        in_low_number   = '0;
        out_high_number = '0;
        out_low_number  = '0;
        tick();
        tick();
        checkState("reset", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        checkState("idle0", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        addBasic();
        runSequence("basic", 3, 1, 1, 0, 1'b0, 1'b0);

        addBasic();
        runSequence("backpressure", 3, 1, 1, 0, 1'b1, 1'b0);

        addExp(7, 5, 1, 1);
        runSequence("single", 5, 5, 7, 7, 1'b0, 1'b0);

        addExp(1, 2, 1, 0);
        addExp(0, 2, 1, 1);
        runSequence("innerInverted", 2, 5, 1, 0, 1'b0, 1'b0);

        addExp(0, 1, 0, 0);
        addExp(0, 0, 1, 1);
        runSequence("lowZero", 1, 0, 0, 0, 1'b0, 1'b0);

        addExp(1023, 1023, 0, 0);
        addExp(1023, 1022, 0, 0);
        addExp(1023, 1021, 1, 1);
        runSequence("topRange", 1023, 1021, 1023, 1023, 1'b0, 1'b0);

        addBasic();
        runSequence("startIgnored", 3, 1, 1, 0, 1'b0, 1'b1);
        addBasic();
        runSequence("restart", 3, 1, 1, 0, 1'b0, 1'b0);

        addr_ready = 1'b1;
        applyStimulus(3, 1, 1, 0);
        tick();
        tick();
        checkState("preReset", 1'b1, 1, 1, 1'b1, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        checkState("midReset", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkState("midResetHold", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        checkState("postReset", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        addBasic();
        runSequence("afterReset", 3, 1, 1, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/count_down_nest_yi.md
Name: count_down_nest_yi

Overview:
Two-level descending index generator. It walks an outer index from out_high_number down to out_low_number. For each outer value it walks an inner index from in_high_number down to in_low_number. Each (outer, inner) pair is presented on a valid/ready stream. It is the downward-stepping counterpart of the team's up-counters, and feeds reverse-order buffer reads (e.g. read-back of tiles written in ascending order).

Parameters:
BITS_OF_END_NUMBER, 10, width of every bound and index.

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  one clock; reset is asynchronous and active-low
start  input  1  one-cycle request; honoured only in IDLE
in_high_number  input  BITS_OF_END_NUMBER  inner first (highest) value
in_low_number  input  BITS_OF_END_NUMBER  inner final (lowest) value
out_high_number  input  BITS_OF_END_NUMBER  outer first value
out_low_number  input  BITS_OF_END_NUMBER  outer final value
addr_ready  input  1  downstream accepts current pair
addr_valid  output  1  inner_q/outer_q hold a valid pair
inner_q  output  BITS_OF_END_NUMBER  current inner index (registered)
outer_q  output  BITS_OF_END_NUMBER  current outer index (registered)
inner_last  output  1  addr_valid & inner_q <= in_low (latched)
seq_last  output  1  inner_last & outer_q <= out_low (latched)
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse in DONE

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; addr_valid, inner_q, outer_q, busy, done all 0; latched bounds 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches all four bounds, loads inner_q<=in_high and outer_q<=out_high, then moves to RUN.
  - Latency: first pair is valid the cycle after start.
  - Bound inputs are don't-care outside the start cycle.
- RUN: addr_valid=1. A beat is addr_valid & addr_ready.
  - No beat: inner_q and outer_q hold stable (stall).
  - Beat with inner_q > in_low_l: inner_q <= inner_q-1.
  - Beat with inner_q <= in_low_l and outer_q > out_low_l: inner_q <= in_high_l, outer_q <= outer_q-1.
  - Beat with seq_last: go to DONE; addr_valid drops next cycle; inner_q and outer_q hold their final values.
- DONE: done=1 for exactly one cycle, then IDLE. busy drops on the IDLE cycle.
- start outside IDLE is ignored, including in the DONE cycle.
- Comparisons are unsigned and use <=. Consequences:
  - high < low at a level produces a single value (high) at that level. No wrap, no underflow.
  - low=0 never decrements below 0, because the reload/terminate branch is taken first.
- inner_last and seq_last are combinational from registered state; no combinational path from addr_ready to addr_valid.
- Beat count = (max(ih-il,0)+1) * (max(oh-ol,0)+1).
- Reset mid-run: immediate return to reset values. No done pulse; the partial sequence is abandoned.
- Bound inputs changing during RUN have no effect.

Decomposition:
- Shared package count_yi_pkg holds:
  - state localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2
  - default BITS_OF_END_NUMBER
- One sub-module, count_down_yi, instantiated twice (inner, outer). Ports: clk, reset, load, enable, high_number, low_number, q, last.
  - load sets q<=high.
  - enable&last sets q<=high.
  - enable&!last sets q<=q-1.

Test Plan:
1. Basic sequence: in 3..1, out 1..0, ready=1, start pulse.
   - Expected (outer,inner): (1,3),(1,2),(1,1),(0,3),(0,2),(0,1) on 6 consecutive cycles.
   - inner_last on beats 3 and 6; seq_last on beat 6.
   - done the next cycle; busy high for 7 cycles.
2. Backpressure: same bounds, ready pattern 1,0,1,0...
   - Same 6 pairs over 11 cycles.
   - Values stable on every ready=0 cycle; addr_valid never drops mid-sequence.
3. Degenerate bounds:
   - in 5..5, out 7..7: one beat (7,5) with inner_last=seq_last=1.
   - in 2..5, out 1..0: pairs (1,2),(0,2) only.
4. Underflow edge: in 1..0, out 0..0, width 10.
   - Expected pairs (0,1),(0,0); inner_q never shows 1023.
   - Also run in 1023..1021, out 1023..1023: pairs 1023,1022,1021.
5. Start handling:
   - start pulses during RUN and on the DONE cycle are ignored; sequence unchanged.
   - start on the following IDLE cycle launches a new sequence.
6. Reset mid-run: drop reset to 0 after beat 2 of scenario 1.
   - Expected immediately: addr_valid, busy, inner_q, outer_q = 0; no done pulse.
   - After release, a fresh start reproduces the full scenario 1 sequence.
